// File: rtl/keycode_repeater.sv
// keycode_repeater
// Turns the raw USB keycode into single-frame typematic pulses for the motion
// block. The raw code is synchronised into frame_clk, reduced to the four
// movement keys (W/A/S/D), debounced, then fed to an IDLE/HOLD/REPEAT
// sequencer. It emits one immediate pulse, then a first repeat after
// HOLD_DELAY frames, then further repeats every REPEAT_PERIOD frames.
//
// Optional build macro: KEY_PRESS_COUNT_EN
//   When defined, the block adds a press_count output. This is a saturating
//   count of accepted presses. A new press from idle counts, and so does a
//   pre-empting key change. Repeat pulses are not counted.
module keycode_repeater #(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned HOLD_DELAY      = 15,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] raw_keycode,
    output logic [7:0] keycode,
`ifdef KEY_PRESS_COUNT_EN
    output logic [7:0] press_count,
`endif
    output logic       key_held
);

    localparam logic [7:0] DEB_LAST    = 8'(DEBOUNCE_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_DELAY - 1);
    localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [7:0] s1_q, s2_q;
    logic [7:0] cand_d;
    logic [7:0] last_cand_q, stab_cnt_q, deb_key_q;
    state_t     state_q;
    logic [7:0] cur_key_q, cnt_q, keycode_q;
    logic       key_held_q;
`ifdef KEY_PRESS_COUNT_EN
    logic [7:0] press_cnt_q;
`endif

    // Two-flop synchroniser: raw_keycode comes from another clock domain.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            s1_q <= 8'h00;
            s2_q <= 8'h00;
        end else begin
            s1_q <= raw_keycode;
            s2_q <= s1_q;
        end
    end

    // Keep only the four movement keys; everything else reads as "no key".
    always_comb begin
        cand_d = 8'h00;
        case (s2_q)
            8'h1A, 8'h04, 8'h16, 8'h07: cand_d = s2_q;
            default:                    cand_d = 8'h00;
        endcase
    end

    // Debounce: accept a candidate once it has been stable for DEBOUNCE_FRAMES more edges.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            last_cand_q <= 8'h00;
            stab_cnt_q  <= 8'h00;
            deb_key_q   <= 8'h00;
        end else if (cand_d != last_cand_q) begin
            last_cand_q <= cand_d;
            stab_cnt_q  <= 8'h00;
        end else if (stab_cnt_q == DEB_LAST) begin
            deb_key_q   <= last_cand_q;
        end else if (stab_cnt_q != 8'hFF) begin
            stab_cnt_q  <= stab_cnt_q + 8'd1;
        end
    end

    // Typematic sequencer. A new key always pre-empts; release wins over everything.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cur_key_q  <= 8'h00;
            cnt_q      <= 8'h00;
            keycode_q  <= 8'h00;
            key_held_q <= 1'b0;
`ifdef KEY_PRESS_COUNT_EN
            press_cnt_q <= 8'h00;
`endif
        end else begin
            keycode_q <= 8'h00;
            case (state_q)
                ST_IDLE: begin
                    if (deb_key_q != 8'h00) begin
                        keycode_q  <= deb_key_q;
                        cur_key_q  <= deb_key_q;
                        cnt_q      <= 8'h00;
                        state_q    <= ST_HOLD;
                        key_held_q <= 1'b1;
`ifdef KEY_PRESS_COUNT_EN
                        if (press_cnt_q != 8'hFF) press_cnt_q <= press_cnt_q + 8'd1;
`endif
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (deb_key_q == 8'h00) begin
                        state_q    <= ST_IDLE;
                        key_held_q <= 1'b0;
                    end else if (deb_key_q != cur_key_q) begin
                        keycode_q  <= deb_key_q;
                        cur_key_q  <= deb_key_q;
                        cnt_q      <= 8'h00;
                        state_q    <= ST_HOLD;
`ifdef KEY_PRESS_COUNT_EN
                        if (press_cnt_q != 8'hFF) press_cnt_q <= press_cnt_q + 8'd1;
`endif
                    end else if (state_q == ST_HOLD && cnt_q == HOLD_LAST) begin
                        keycode_q <= cur_key_q;
                        cnt_q     <= 8'h00;
                        state_q   <= ST_REPEAT;
                    end else if (state_q == ST_REPEAT && cnt_q == REPEAT_LAST) begin
                        keycode_q <= cur_key_q;
                        cnt_q     <= 8'h00;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    key_held_q <= 1'b0;
                end
            endcase
        end
    end

    assign keycode  = keycode_q;
    assign key_held = key_held_q;
`ifdef KEY_PRESS_COUNT_EN
    assign press_count = press_cnt_q;
`endif

endmodule

// File: tb/tb_keycode_repeater.sv
// Bench for keycode_repeater. A behavioural model tracks the expected outputs.
// The model keeps a window of recent filtered samples to find the debounced
// key, and it tracks frames since the press to place the pulses. Directed
// scenarios are followed by randomised key sequences with occasional resets.
module tb_keycode_repeater;

    localparam int DF = 2;
    localparam int HD = 15;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw;
    logic [7:0] kc;
    logic       held;
`ifdef KEY_PRESS_COUNT_EN
    logic [7:0] pc;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    logic [7:0] m_s1, m_s2, m_deb, m_key, m_kc;
    logic [7:0] hist[$];
    logic       m_held;
    int         m_age;
    int         m_presses;

    always #5 clk = ~clk;

    keycode_repeater #(
        .DEBOUNCE_FRAMES(DF),
        .HOLD_DELAY     (HD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .frame_clk  (clk),
        .Reset      (rst),
        .raw_keycode(raw),
        .keycode    (kc),
`ifdef KEY_PRESS_COUNT_EN
        .press_count(pc),
`endif
        .key_held   (held)
    );

    function automatic logic [7:0] filt(input logic [7:0] v);
        return (v == 8'h1A || v == 8'h04 || v == 8'h16 || v == 8'h07) ? v : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %02h expected %02h", tag, $time, obs, exp);
        end
    endtask

    // One clock edge of the reference behaviour, using inputs present at the edge.
    task automatic model_edge();
        logic [7:0] d;
        logic [7:0] pulse;
        logic       same;
        if (rst) begin
            m_s1 = 8'h00; m_s2 = 8'h00; m_deb = 8'h00; m_key = 8'h00; m_kc = 8'h00;
            m_held = 1'b0; m_age = 0; m_presses = 0;
            hist = {};
            for (int i = 0; i <= DF; i++) hist.push_back(8'h00);
        end else begin
            d = m_deb;
            pulse = 8'h00;
            if (!m_held) begin
                if (d != 8'h00) begin
                    pulse = d; m_held = 1'b1; m_key = d; m_age = 0; m_presses++;
                end
            end else if (d == 8'h00) begin
                m_held = 1'b0;
            end else if (d != m_key) begin
                pulse = d; m_key = d; m_age = 0; m_presses++;
            end else begin
                m_age++;
                if (m_age == HD || (m_age > HD && (m_age - HD) % RP == 0)) pulse = m_key;
            end
            m_kc = pulse;
            // debounced key = a filtered value seen on DF+1 consecutive edges
            hist.push_back(filt(m_s2));
            void'(hist.pop_front());
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same) m_deb = hist[0];
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic tick();
        logic [7:0] exp_pc;
        @(posedge clk);
        model_edge();
        #1;
        check("keycode", kc, m_kc);
        check("key_held", {7'b0, held}, {7'b0, m_held});
`ifdef KEY_PRESS_COUNT_EN
        exp_pc = (m_presses > 255) ? 8'hFF : 8'(m_presses);
        check("press_count", pc, exp_pc);
`else
        exp_pc = 8'h00;
`endif
    endtask

    task automatic hold(input logic [7:0] key, input int frames);
        raw = key;
        for (int i = 0; i < frames; i++) tick();
    endtask

    task automatic do_reset(input int frames);
        rst = 1'b1;
        for (int i = 0; i < frames; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] keys[7];
        logic [7:0] k;
        keys = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h00, 8'h2C, 8'h1A};
        rst = 1'b1;
        raw = 8'h00;

        // reset state
        do_reset(2);
        check("reset_keycode", kc, 8'h00);
        check("reset_key_held", {7'b0, held}, 8'h00);

        // default press: 40 frames of W then release
        hold(8'h1A, 40);
        hold(8'h00, 12);

        // short glitch must be rejected
        hold(8'h04, 2);
        hold(8'h00, 20);

        // non-movement key is filtered out
        hold(8'h2C, 30);
        hold(8'h00, 6);

        // A into repeat, then switch straight to D
        hold(8'h04, 30);
        hold(8'h07, 30);
        hold(8'h00, 8);

        // reset in the middle of repeating S
        hold(8'h16, 30);
        do_reset(1);
        check("midreset_keycode", kc, 8'h00);
        check("midreset_key_held", {7'b0, held}, 8'h00);
        hold(8'h16, 25);
        hold(8'h00, 8);

        // randomised key sequences
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 14) == 0) do_reset(1);
            if ($urandom_range(0, 5) == 0) k = 8'($urandom_range(0, 255));
            else k = keys[$urandom_range(0, 6)];
            hold(k, $urandom_range(1, 40));
        end
        hold(8'h00, 8);

`ifdef KEY_PRESS_COUNT_EN
        // counter saturation over many presses
        do_reset(1);
        hold(8'h1A, 40); hold(8'h00, 6);
        hold(8'h04, 40); hold(8'h00, 6);
        hold(8'h07, 40); hold(8'h00, 6);
        check("press_count_three", pc, 8'd3);
        for (int p = 0; p < 300; p++) begin
            hold(keys[p % 4], 6);
            hold(8'h00, 6);
        end
        check("press_count_sat", pc, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
